axi_stream_master: RTL and testbench
====================================

Name: axi_stream_master

Overview:
AXI4-Stream transmitter at the output of the video enhancement datapath, the opposite end of the input stream slave. Accepts processed pixels from the datapath and buffers them in a small FIFO. Drives TDATA/TVALID with TUSER (start of frame) and TLAST (end of line) framing toward the downstream sink. Applies registered backpressure to the datapath through datapath_ready.

Parameters:
FIFO_DEPTH, 4, FIFO entries; power of two, minimum 4
IMG_WIDTH, 1280, pixels per line
IMG_HEIGHT, 720, lines per frame

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
resetN  in  1  synchronous active-low soft reset (frame flush)
pix_in  in  FDATA(32)  processed pixel from datapath
pix_valid  in  1  pix_in valid this cycle
datapath_ready  out  1  registered; datapath may issue pixels while high
TDATA  out  FDATA(32)  stream data
TVALID  out  1  stream valid
TREADY  in  1  sink ready
TUSER  out  1  high on first pixel of frame (row 0, col 0)
TLAST  out  1  high on last pixel of each line (col IMG_WIDTH-1)
frame_done  out  1  one-cycle pulse when last pixel of frame is transferred
overflow  out  1  sticky; a pixel was dropped because the FIFO was full

Behaviour:
- Reset: ARESETn is asynchronous, active-low; clock is ACLK. ARESETn low, or resetN low at a rising edge, sets all outputs to 0, empties the FIFO, and clears col/row counters and overflow.
- Reset mid-frame: buffered pixels are discarded. TVALID falls immediately on ARESETn, or at the next edge on resetN. The next accepted pixel is tagged TUSER.
- Write: the push condition is pix_valid & (count < FIFO_DEPTH | pop this cycle). If pix_valid is high and push is refused, the pixel is dropped, overflow is set to 1, and the counters do not advance.
- Tagging at push: the entry stores {TUSER, TLAST, pix_in}. TUSER = (row==0 & col==0). TLAST = (col==IMG_WIDTH-1).
- Counters: col increments on each push. At IMG_WIDTH-1 it wraps to 0 and row increments. row wraps from IMG_HEIGHT-1 to 0. Widths are $clog2 of IMG_WIDTH and IMG_HEIGHT.
- Read: TVALID = count != 0. TDATA/TUSER/TLAST come from the head entry, read from the registered array by pointer. Pop = TVALID & TREADY.
- AXI rule: once TVALID is asserted, TVALID, TDATA, TUSER and TLAST hold stable until TREADY. TVALID never depends combinationally on TREADY.
- Latency: a pixel pushed at edge N is visible on TVALID at N+1 if the FIFO was empty. There is no bypass path.
- Simultaneous push and pop: count is unchanged. This is legal when full (push accepted) and when count==1.
- datapath_ready is registered: next value = (count_next <= FIFO_DEPTH-2). The one-entry margin absorbs the pixel issued in the cycle after ready drops. Reset value is 0; it rises 1 cycle after reset release.
- frame_done: 1-cycle pulse registered on the pop of an entry with TLAST=1 at row IMG_HEIGHT-1. A row tag bit is kept per entry for this purpose.
- Pointers: wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH, width $clog2(FIFO_DEPTH)+1.

Decomposition:
- Package pkg: FDATA (32-bit), typedef out_entry_t {logic sof; logic eol; logic eof; FDATA data}, default IMG_WIDTH/IMG_HEIGHT constants.
- Sub-module stream_fifo: parameterised FIFO of out_entry_t with push/pop/count/full/empty. The top level holds the counters, tagging, ready and flag logic.

Test Plan:
- Reset behaviour: IMG_WIDTH=4, IMG_HEIGHT=2, TREADY=1, 8 pixels 0x1..0x8 back-to-back. Each pixel must appear 1 cycle after its push. TUSER is high on 0x1 only. TLAST is high on 0x4 and 0x8. frame_done pulses on the 0x8 transfer. datapath_ready stays 1.
- Backpressure: TREADY=0 with continuous pix_valid gated by datapath_ready, FIFO_DEPTH=4. datapath_ready must fall after 2-3 pushes, count must reach at most 4, and overflow stays 0. TDATA/TVALID must be stable for the whole stall.
- Forced overflow: ignore datapath_ready and push 6 pixels with TREADY=0. overflow must go high on the 5th push. The col counter advances only 4. After TREADY=1, exactly 4 pixels are output in order.
- Simultaneous events: with the FIFO full, push and pop in the same cycle. count must stay 4 and the new pixel must be accepted. With count==1, the same must hold with TVALID staying high.
- Reset mid-frame: resetN low after pixel 3 of a line with 2 entries buffered. TVALID must be 0 at the next edge and counters cleared. The first pixel after release must carry TUSER=1. Repeat with asynchronous ARESETn: TVALID must drop without a clock edge.
- Random stall: randomised TREADY (50%) over 3 frames with IMG_WIDTH=5, IMG_HEIGHT=3. A scoreboard checks data order, TUSER/TLAST positions and 3 frame_done pulses.

Source files
------------

// File: rtl/axi_stream_master_pkg.sv
// Shared types and defaults for the output stream transmitter.
// Pure declarations, no logic or latency.
// No flow control here; users apply their own handshakes.
package axi_stream_master_pkg;

  localparam int FDATA_W = 32;
  typedef logic [FDATA_W-1:0] FDATA;

  localparam int DEF_IMG_WIDTH  = 1280;
  localparam int DEF_IMG_HEIGHT = 720;

  // One queued pixel with the framing decided when it was accepted.
  // eof marks a pixel that belongs to the last line of the frame.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
    FDATA data;
  } out_entry_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_stream_master_if.sv
// Pixel stream bus between the transmitter and the downstream sink.
// Wires only, no latency.
// The sink throttles the source with TREADY; TVALID never waits on it.
interface axi_stream_master_if;
  import axi_stream_master_pkg::*;

  FDATA TDATA;
  logic TVALID;
  logic TREADY;
  logic TUSER;
  logic TLAST;

  modport master (output TDATA, output TVALID, output TUSER, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TUSER, input TLAST, output TREADY);

endinterface

// File: rtl/axi_stream_master_fifo.sv
// Small queue of tagged pixels with an occupancy count and lookahead count.
// Head entry is read straight from the storage array; a push shows at the head one edge later.
// Caller must only push when not full (or popping) and only pop when not empty.
module axi_stream_master_fifo
  import axi_stream_master_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int QW = AW + 1
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       resetN,
  input  logic       push,
  input  out_entry_t push_dat,
  input  logic       pop,
  output out_entry_t head_dat,
  output logic [QW-1:0] count,
  output logic [QW-1:0] count_next,
  output logic       full,
  output logic       empty
);

  out_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Simultaneous push and pop leaves the occupancy unchanged.
  assign count_next = count + QW'(push) - QW'(pop);
  assign full       = (count == QW'(DEPTH));
  assign empty      = (count == '0);
  assign head_dat   = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two; a soft reset flushes.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/axi_stream_master.sv
// Pixel stream transmitter: tags datapath pixels with start-of-frame / end-of-line and queues them for the sink.
// Latency: a pixel accepted at edge N appears on TVALID at N+1 when the queue was empty (no bypass).
// Backpressure: registered datapath_ready keeps one spare entry; pixels arriving when no space is left are dropped and flagged.
module axi_stream_master
  import axi_stream_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic resetN,
  input  FDATA pix_in,
  input  logic pix_valid,
  output logic datapath_ready,
  axi_stream_master_if.master axis,
  output logic frame_done,
  output logic overflow
);

  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam int QW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [QW-1:0] RDY_MAX  = QW'(FIFO_DEPTH - 2);
  localparam logic [QW-1:0] CNT_MAX  = QW'(FIFO_DEPTH);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [QW-1:0] fifo_count;
  logic [QW-1:0] fifo_count_next;
  out_entry_t    wr_entry;
  out_entry_t    head;

  // A full queue still takes a pixel when the head leaves in the same cycle.
  assign pop  = ~fifo_empty & axis.TREADY;
  assign push = pix_valid & (~fifo_full | pop);

  // Framing is decided from the position of the pixel as it is accepted.
  always_comb begin
    wr_entry      = '0;
    wr_entry.sof  = (row == '0) && (col == '0);
    wr_entry.eol  = (col == COL_LAST);
    wr_entry.eof  = (row == ROW_LAST);
    wr_entry.data = pix_in;
  end

  axi_stream_master_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .resetN     (resetN),
    .push       (push),
    .push_dat   (wr_entry),
    .pop        (pop),
    .head_dat   (head),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Stream outputs come from the head entry and read as zero while nothing is queued.
  assign axis.TVALID = ~fifo_empty;
  assign axis.TDATA  = fifo_empty ? '0 : head.data;
  assign axis.TUSER  = ~fifo_empty & head.sof;
  assign axis.TLAST  = ~fifo_empty & head.eol;

  // Position of the next pixel to be accepted; refused pixels do not move it.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      col <= '0;
      row <= '0;
    end else if (!resetN) begin
      col <= '0;
      row <= '0;
    end else if (push) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Ready looks ahead at next occupancy so the pixel issued just after it drops still fits.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      datapath_ready <= 1'b0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
    end else if (!resetN) begin
      datapath_ready <= 1'b0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      datapath_ready <= (fifo_count_next <= RDY_MAX);
      frame_done     <= pop & head.eol & head.eof;
      if (pix_valid & ~push) overflow <= 1'b1;
    end
  end

  a_count_bound: assert property (@(posedge ACLK) disable iff (!ARESETn) fifo_count <= CNT_MAX);

endmodule

// File: tb/tb_axi_stream_master.sv
module tb_axi_stream_master;

  localparam int DEPTH = 4;

  logic        ACLK = 1'b0;
  logic [1:0]  arst_n;
  logic [1:0]  srst_n;
  logic [1:0]  pix_valid;
  logic [1:0]  tready;
  logic [31:0] pix_in [2];
  logic [1:0]  tvalid, tuser, tlast, rdy, fdone, ovf;
  logic [31:0] tdata [2];
  logic        chk_en = 1'b0;
  logic        rdy_prev;
  int          n_chk = 0;
  int          n_fail = 0;
  int          fd_cnt = 0;
  int          got, sent, np;

  always #5 ACLK = ~ACLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instance 0 is 4x2 for directed tests, instance 1 is 5x3 for the random run.
  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int W  = (gi == 0) ? 4 : 5;
    localparam int H  = (gi == 0) ? 2 : 3;
    localparam int FR = W * H;

    axi_stream_master_if axis ();
    assign axis.TREADY = tready[gi];
    assign tvalid[gi]  = axis.TVALID;
    assign tdata[gi]   = axis.TDATA;
    assign tuser[gi]   = axis.TUSER;
    assign tlast[gi]   = axis.TLAST;

    axi_stream_master #(
      .FIFO_DEPTH (DEPTH),
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
    ) u_dut (
      .ACLK           (ACLK),
      .ARESETn        (arst_n[gi]),
      .resetN         (srst_n[gi]),
      .pix_in         (pix_in[gi]),
      .pix_valid      (pix_valid[gi]),
      .datapath_ready (rdy[gi]),
      .axis           (axis),
      .frame_done     (fdone[gi]),
      .overflow       (ovf[gi])
    );

    // Reference: queue of accepted pixels, each with its index since reset;
    // frame position is that index modulo line and frame size.
    logic [31:0] mq_d [$];
    int          mq_k [$];
    int          mk = 0;
    logic        m_ovf = 1'b0, m_fd = 1'b0, m_rdy = 1'b0;
    logic        pop_now, room;

    initial forever begin
      @(posedge ACLK or negedge arst_n[gi]);
      if (!arst_n[gi] || !srst_n[gi]) begin
        mq_d.delete();
        mq_k.delete();
        mk = 0; m_ovf = 1'b0; m_fd = 1'b0; m_rdy = 1'b0;
      end else begin
        pop_now = (mq_d.size() != 0) && tready[gi];
        room    = (mq_d.size() < DEPTH) || pop_now;
        m_fd    = 1'b0;
        if (pop_now) begin
          m_fd = ((mq_k[0] % FR) == FR - 1);
          void'(mq_d.pop_front());
          void'(mq_k.pop_front());
        end
        if (pix_valid[gi]) begin
          if (room) begin
            mq_d.push_back(pix_in[gi]);
            mq_k.push_back(mk);
            mk++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        m_rdy = (mq_d.size() <= DEPTH - 2);
      end
    end

    initial forever begin
      @(negedge ACLK);
      if (chk_en) begin
        check_val($sformatf("g%0d_tvalid", gi), 32'(tvalid[gi]), 32'(mq_d.size() != 0));
        if (mq_d.size() != 0) begin
          check_val($sformatf("g%0d_tdata", gi), tdata[gi], mq_d[0]);
          check_val($sformatf("g%0d_tuser", gi), 32'(tuser[gi]), 32'((mq_k[0] % FR) == 0));
          check_val($sformatf("g%0d_tlast", gi), 32'(tlast[gi]), 32'((mq_k[0] % W) == W - 1));
        end
        check_val($sformatf("g%0d_ready", gi), 32'(rdy[gi]), 32'(m_rdy));
        check_val($sformatf("g%0d_overflow", gi), 32'(ovf[gi]), 32'(m_ovf));
        check_val($sformatf("g%0d_frame_done", gi), 32'(fdone[gi]), 32'(m_fd));
      end
    end
  end

  initial forever begin
    @(negedge ACLK);
    if (fdone[1]) fd_cnt++;
  end

  task automatic drive0(input logic v, input logic [31:0] d, input logic r);
    pix_valid[0] = v;
    pix_in[0]    = d;
    tready[0]    = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 2'b00; srst_n = 2'b11; pix_valid = 2'b00; tready = 2'b00;
    pix_in[0] = '0; pix_in[1] = '0;
    repeat (3) @(negedge ACLK);
    check_val("rst_tvalid", 32'(tvalid[0]), 0);
    check_val("rst_tdata", tdata[0], 0);
    check_val("rst_ready", 32'(rdy[0]), 0);
    check_val("rst_overflow", 32'(ovf[0]), 0);
    check_val("rst_frame_done", 32'(fdone[0]), 0);
    arst_n = 2'b11;
    chk_en = 1'b1;
    @(negedge ACLK);
    check_val("rst_ready_rise", 32'(rdy[0]), 1);

    // Back-to-back frame, sink always ready
    for (int j = 0; j <= 9; j++) begin
      if (j >= 1 && j <= 8) begin
        check_val("t1_data", tdata[0], 32'(j));
        check_val("t1_tuser", 32'(tuser[0]), 32'(j == 1));
        check_val("t1_tlast", 32'(tlast[0]), 32'(j == 4 || j == 8));
        check_val("t1_frame_done_low", 32'(fdone[0]), 0);
        check_val("t1_ready", 32'(rdy[0]), 1);
      end
      if (j == 9) check_val("t1_frame_done_pulse", 32'(fdone[0]), 1);
      drive0(j < 8, 32'(j + 1), 1'b1);
      @(negedge ACLK);
    end
    check_val("t1_frame_done_single", 32'(fdone[0]), 0);

    // Stall: datapath reacts to ready one cycle late
    rdy_prev = rdy[0];
    np = 0;
    for (int j = 0; j < 10; j++) begin
      if (j >= 1) begin
        check_val("t2_stall_tvalid", 32'(tvalid[0]), 1);
        check_val("t2_stall_tdata", tdata[0], 32'h11);
      end
      if (j == 2) check_val("t2_ready_high", 32'(rdy[0]), 1);
      if (j == 3) check_val("t2_ready_fall", 32'(rdy[0]), 0);
      drive0(rdy_prev, 32'h11 + 32'(np), 1'b0);
      if (rdy_prev) np++;
      rdy_prev = rdy[0];
      @(negedge ACLK);
    end
    check_val("t2_overflow", 32'(ovf[0]), 0);

    // Full queue: push and pop together
    drive0(1'b1, 32'h15, 1'b1);
    @(negedge ACLK);
    check_val("t4_full_tvalid", 32'(tvalid[0]), 1);
    check_val("t4_full_head", tdata[0], 32'h12);
    check_val("t4_full_ready", 32'(rdy[0]), 0);
    check_val("t4_full_overflow", 32'(ovf[0]), 0);
    drive0(1'b0, 0, 1'b1);
    repeat (3) @(negedge ACLK);
    check_val("t4_one_head", tdata[0], 32'h15);
    drive0(1'b1, 32'h16, 1'b1);
    @(negedge ACLK);
    check_val("t4_one_tvalid", 32'(tvalid[0]), 1);
    check_val("t4_one_head_new", tdata[0], 32'h16);
    drive0(1'b0, 0, 1'b1);
    @(negedge ACLK);
    check_val("t4_drained", 32'(tvalid[0]), 0);

    // Forced overflow
    drive0(1'b0, 0, 1'b0);
    srst_n[0] = 1'b0;
    @(negedge ACLK);
    srst_n[0] = 1'b1;
    @(negedge ACLK);
    for (int j = 0; j < 6; j++) begin
      drive0(1'b1, 32'h21 + 32'(j), 1'b0);
      @(negedge ACLK);
      check_val("t3_overflow", 32'(ovf[0]), 32'(j >= 4));
    end
    drive0(1'b0, 0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      check_val("t3_drain_tvalid", 32'(tvalid[0]), 1);
      check_val("t3_drain_data", tdata[0], 32'h21 + 32'(j));
      check_val("t3_drain_tlast", 32'(tlast[0]), 32'(j == 3));
      @(negedge ACLK);
    end
    check_val("t3_exactly_four", 32'(tvalid[0]), 0);
    for (int j = 0; j < 4; j++) begin
      drive0(1'b1, 32'h27 + 32'(j), 1'b1);
      @(negedge ACLK);
      check_val("t3_next_data", tdata[0], 32'h27 + 32'(j));
      check_val("t3_next_tuser", 32'(tuser[0]), 0);
      check_val("t3_next_tlast", 32'(tlast[0]), 32'(j == 3));
    end
    drive0(1'b0, 0, 1'b1);
    @(negedge ACLK);
    check_val("t3_frame_done", 32'(fdone[0]), 1);

    // Soft reset mid-line with two entries queued
    drive0(1'b1, 32'h31, 1'b1);
    @(negedge ACLK);
    drive0(1'b1, 32'h32, 1'b1);
    @(negedge ACLK);
    drive0(1'b1, 32'h33, 1'b0);
    @(negedge ACLK);
    drive0(1'b0, 0, 1'b0);
    check_val("t5_buffered_head", tdata[0], 32'h32);
    srst_n[0] = 1'b0;
    @(negedge ACLK);
    check_val("t5_srst_tvalid", 32'(tvalid[0]), 0);
    check_val("t5_srst_tdata", tdata[0], 0);
    check_val("t5_srst_overflow", 32'(ovf[0]), 0);
    check_val("t5_srst_ready", 32'(rdy[0]), 0);
    srst_n[0] = 1'b1;
    @(negedge ACLK);
    drive0(1'b1, 32'h34, 1'b1);
    @(negedge ACLK);
    check_val("t5_first_data", tdata[0], 32'h34);
    check_val("t5_first_tuser", 32'(tuser[0]), 1);

    // Async reset drops TVALID without a clock edge
    drive0(1'b0, 0, 1'b1);
    @(negedge ACLK);
    drive0(1'b1, 32'h41, 1'b0);
    @(negedge ACLK);
    drive0(1'b1, 32'h42, 1'b0);
    @(negedge ACLK);
    drive0(1'b0, 0, 1'b0);
    check_val("t5_async_pre_tvalid", 32'(tvalid[0]), 1);
    #1 arst_n[0] = 1'b0;
    #1;
    check_val("t5_async_tvalid", 32'(tvalid[0]), 0);
    check_val("t5_async_tdata", tdata[0], 0);
    @(negedge ACLK);
    arst_n[0] = 1'b1;
    @(negedge ACLK);
    check_val("t5_async_ready", 32'(rdy[0]), 1);
    drive0(1'b1, 32'h43, 1'b1);
    @(negedge ACLK);
    check_val("t5_async_first_data", tdata[0], 32'h43);
    check_val("t5_async_first_tuser", 32'(tuser[0]), 1);
    drive0(1'b0, 0, 1'b0);
    @(negedge ACLK);

    // Random sink stalls over three 5x3 frames
    got = 0;
    sent = 0;
    for (int cyc = 0; cyc < 4000 && got < 45; cyc++) begin
      @(negedge ACLK);
      tready[1] = 1'($urandom_range(0, 1));
      if (tvalid[1] && tready[1]) begin
        check_val("rnd_data", tdata[1], 32'h100 + 32'(got));
        check_val("rnd_tuser", 32'(tuser[1]), 32'((got % 15) == 0));
        check_val("rnd_tlast", 32'(tlast[1]), 32'((got % 5) == 4));
        got++;
      end
      if (rdy[1] && sent < 45 && $urandom_range(0, 3) != 0) begin
        pix_valid[1] = 1'b1;
        pix_in[1]    = 32'h100 + 32'(sent);
        sent++;
      end else begin
        pix_valid[1] = 1'b0;
      end
    end
    check_val("rnd_pixel_count", 32'(got), 45);
    @(negedge ACLK);
    tready[1] = 1'b0;
    pix_valid[1] = 1'b0;
    repeat (3) @(negedge ACLK);
    check_val("rnd_frame_done_count", 32'(fd_cnt), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
